dcache_line_reader: RTL and testbench

//   Read-side initiator for the data-cache dual-port BRAM: on a request, reads one full

---
 rtl/dcache_line_reader.sv | 115 +++++++++++
 tb/tb_dcache_line_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_line_reader.sv
// Streams one cache line out of a dual-port BRAM read port, word by word, on a valid/ready beat
// interface. A 2-entry skid buffer absorbs the BRAM's one-cycle read latency under backpressure.
module dcache_line_reader #(
   parameter  int DATA_WIDTH   = 32,
   parameter  int INDEX_WIDTH  = 6,
   parameter  int OFFSET_WIDTH = 2,
   localparam int ADDR_WIDTH   = INDEX_WIDTH + OFFSET_WIDTH
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start_valid,
   output logic                    start_ready,
   input  logic [INDEX_WIDTH-1:0]  start_index,
   output logic [ADDR_WIDTH-1:0]   bram_rdaddress,
   output logic                    bram_rden,
   input  logic [DATA_WIDTH-1:0]   bram_q,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_last,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                  state;
   logic [INDEX_WIDTH-1:0]  index;
   logic [OFFSET_WIDTH-1:0] issue_ctr;
   logic                    inflight;
   logic                    inflight_last;
   logic [DATA_WIDTH-1:0]   fifo_data [2];
   logic                    fifo_last [2];
   logic                    rd_ptr;
   logic                    wr_ptr;
   logic [1:0]              occ;

   logic                    pop;
   logic                    push;
   logic                    issue;
   logic                    last_issue;
   logic [2:0]              credit_sum;

   // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
   always_comb begin
      pop        = out_valid && out_ready;
      push       = inflight;
      // Words already owned (buffered + returning) after this cycle's pop; pop implies occ>=1.
      credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      issue      = (state == READ) && (credit_sum < 3'd2);
      last_issue = issue && (issue_ctr == {OFFSET_WIDTH{1'b1}});
   end

   assign bram_rden      = issue;
   assign bram_rdaddress = {index, issue_ctr};
   assign start_ready    = (state == IDLE);
   assign busy           = (state != IDLE);
   assign out_valid      = (occ != 2'd0);
   assign out_data       = fifo_data[rd_ptr];
   assign out_last       = fifo_last[rd_ptr];

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         index         <= '0;
         issue_ctr     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         occ           <= 2'd0;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         // NOTE: the two buffer entries are plain flops, cleared so out_data reads 0 after reset.
         fifo_data[0]  <= '0;
         fifo_data[1]  <= '0;
         fifo_last[0]  <= 1'b0;
         fifo_last[1]  <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_last <= last_issue;
         if (push) begin
            fifo_data[wr_ptr] <= bram_q;
            fifo_last[wr_ptr] <= inflight_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         occ <= occ + 2'(push) - 2'(pop);

         case (state)
            IDLE: begin
               if (start_valid) begin
                  index     <= start_index;
                  issue_ctr <= '0;
                  state     <= READ;
               end
            end
            READ: begin
               // Counter stops on the final offset so the address holds steady while draining.
               if (issue) begin
                  if (last_issue)
                     state <= DRAIN;
                  else
                     issue_ctr <= issue_ctr + 1'b1;
               end
            end
            DRAIN: begin
               if (pop && out_last)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_line_reader.sv
// Bench for dcache_line_reader: BRAM model, line-level scoreboard fed at each start handshake,
// directed latency/backpressure/reset/back-to-back scenarios and randomized line traffic.
module tb_dcache_line_reader;

   localparam int DW  = 32;
   localparam int IW  = 6;
   localparam int OW  = 2;
   localparam int AW  = IW + OW;
   localparam int WPL = 1 << OW;

   logic          clock;
   logic          reset;
   logic          start_valid;
   logic          start_ready;
   logic [IW-1:0] start_index;
   logic [AW-1:0] bram_rdaddress;
   logic          bram_rden;
   logic [DW-1:0] bram_q;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;

   logic [DW-1:0] mem [1 << AW];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc   = 0;

   dcache_line_reader #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)) dut (
      .clock          (clock),
      .reset          (reset),
      .start_valid    (start_valid),
      .start_ready    (start_ready),
      .start_index    (start_index),
      .bram_rdaddress (bram_rdaddress),
      .bram_rden      (bram_rden),
      .bram_q         (bram_q),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // BRAM read port: registered address, data one cycle after rden
   always @(posedge clock)
      if (bram_rden) bram_q <= mem[bram_rdaddress];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: each accepted start queues the four words of that line, in offset order.
   task automatic monitor();
      logic [32:0] exp_q [$];
      logic [AW-1:0] addr_q [$];
      logic [32:0] e;
      int issued = 0;
      int popped = 0;
      int beats  = 0;
      int a;
      forever begin
         @(negedge clock);
         if (reset) begin
            exp_q.delete();
            addr_q.delete();
            issued = 0;
            popped = 0;
            beats  = 0;
         end else begin
            if (start_valid && start_ready)
               for (int k = 0; k < WPL; k++) begin
                  a = int'(start_index) * WPL + k;
                  exp_q.push_back({k == WPL - 1, mem[a]});
                  addr_q.push_back(AW'(a));
               end
            if (bram_rden) begin
               if (addr_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
               else check("rdaddr", 32'(bram_rdaddress), 32'(addr_q.pop_front()));
               check("outstanding_le2",
                     32'((issued - popped + 1 - int'(out_valid && out_ready)) <= 2), 32'd1);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check("beat_unexpected", 32'd1, 32'd0);
               else begin
                  e = exp_q.pop_front();
                  check("out_data", out_data, e[31:0]);
                  check("out_last", 32'(out_last), 32'(e[32]));
               end
               beats++;
               if (out_last) begin
                  check("beats_per_line", 32'(beats), 32'(WPL));
                  beats = 0;
               end
            end
            issued += int'(bram_rden);
            popped += int'(out_valid && out_ready);
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_idle(input int budget, input bit rnd);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         done = !busy;
         step();
      end
      if (!done) check("idle_timeout", 32'd0, 32'd1);
      out_ready = 1'b1;
   endtask

   task automatic run_line(input logic [IW-1:0] idx, input bit rnd);
      bit hs = 1'b0;
      start_index = idx;
      start_valid = 1'b1;
      for (int i = 0; i < 20 && !hs; i++) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         hs = start_ready;
         step();
      end
      start_valid = 1'b0;
      if (!hs) check("start_timeout", 32'd0, 32'd1);
      wait_idle(200, rnd);
   endtask

   initial begin
      int n_rd;
      int hs_count;
      int last_pop_cyc;

      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      for (int k = 0; k < WPL; k++) mem[5 * WPL + k] = 32'h1000 + 32'(k);

      reset       = 1'b1;
      start_valid = 1'b0;
      start_index = '0;
      out_ready   = 1'b1;
      fork monitor(); join_none
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clock);
      check("rst_start_ready", 32'(start_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rden", 32'(bram_rden), 32'd0);
      check("rst_rdaddr", 32'(bram_rdaddress), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      step();

      // Line 5 at full throughput: addresses 20..23, beats 0x1000..0x1003, done in 6 cycles
      start_index = 6'd5;
      start_valid = 1'b1;
      @(negedge clock);
      check("t1_handshake", 32'(start_ready), 32'd1);
      step();
      start_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         check("t1_busy", 32'(busy), 32'd1);
         check("t1_rden", 32'(bram_rden), 32'(c <= 4));
         if (c <= 4) check("t1_rdaddr", 32'(bram_rdaddress), 32'(20 + c - 1));
         check("t1_out_valid", 32'(out_valid), 32'(c >= 3));
         if (c >= 3) begin
            check("t1_out_data", out_data, 32'h1000 + 32'(c - 3));
            check("t1_out_last", 32'(out_last), 32'(c == 6));
         end
         step();
      end
      @(negedge clock);
      check("t1_busy_done", 32'(busy), 32'd0);
      check("t1_ready_done", 32'(start_ready), 32'd1);
      step();

      // Backpressure from the first beat: reads stop with two words owned, beat held stable
      start_index = 6'd7;
      start_valid = 1'b1;
      @(negedge clock);
      step();
      start_valid = 1'b0;
      n_rd = 0;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clock);
         n_rd += int'(bram_rden);
         step();
      end
      out_ready = 1'b0;
      for (int c = 3; c <= 6; c++) begin
         @(negedge clock);
         n_rd += int'(bram_rden);
         check("t2_rden_stalled", 32'(bram_rden), 32'd0);
         check("t2_out_valid_held", 32'(out_valid), 32'd1);
         check("t2_out_data_held", out_data, mem[7 * WPL]);
         step();
      end
      check("t2_reads_before_release", 32'(n_rd), 32'd2);
      out_ready = 1'b1;
      wait_idle(50, 1'b0);

      // Randomized lines with random backpressure
      for (int n = 0; n < 100; n++) run_line(IW'($urandom_range(0, 63)), 1'b1);

      // Reset with two beats buffered, then line 63 (addresses 252..255)
      out_ready   = 1'b0;
      start_index = 6'd9;
      start_valid = 1'b1;
      @(negedge clock);
      step();
      start_valid = 1'b0;
      for (int c = 1; c <= 4; c++) step();
      reset = 1'b1;
      @(negedge clock);
      check("t4_buffered_before_reset", 32'(out_valid), 32'd1);
      step();
      reset = 1'b0;
      @(negedge clock);
      check("t4_out_valid", 32'(out_valid), 32'd0);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_start_ready", 32'(start_ready), 32'd1);
      check("t4_rdaddr", 32'(bram_rdaddress), 32'd0);
      step();
      out_ready = 1'b1;
      run_line(6'd63, 1'b0);

      // start_valid held high: second line accepted one cycle after the first last beat
      out_ready    = 1'b1;
      start_index  = 6'd11;
      start_valid  = 1'b1;
      hs_count     = 0;
      last_pop_cyc = -100;
      for (int i = 0; i < 40 && hs_count < 2; i++) begin
         @(negedge clock);
         if (busy) check("t5_ready_while_busy", 32'(start_ready), 32'd0);
         if (start_ready) begin
            hs_count++;
            if (hs_count == 2) check("t5_restart_gap", 32'(cyc - last_pop_cyc), 32'd1);
         end
         if (out_valid && out_ready && out_last) last_pop_cyc = cyc;
         step();
         start_index = IW'($urandom_range(0, 63));
      end
      start_valid = 1'b0;
      check("t5_two_lines", 32'(hs_count), 32'd2);
      wait_idle(50, 1'b0);

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
